cic_interp_m256_n1_iw13: RTL
============================

CIC_INTERP_M256_N1_IW13 -- requirements
Module: cic_interp_m256_n1_iw13

Interface
REQ-001 SHALL have no parameters; widths fixed: input 13b, internal 14b, output 13b, max rate 256.
REQ-002 SHALL have port: clk  in  1  rising-edge clock for all logic.
REQ-003 SHALL have port: sync_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: msetting  in  9  interpolation rate R, legal values 1..256; 0 is treated as 1.
REQ-005 SHALL have port: s_axis_tvalid  in  1  input sample valid.
REQ-006 SHALL have port: s_axis_tdata  in  13  signed input sample.
REQ-007 SHALL have port: s_axis_tready  out  1  input accept.
REQ-008 SHALL have port: m_axis_tvalid  out  1  output sample valid.
REQ-009 SHALL have port: m_axis_tdata  out  13  signed output sample.
REQ-010 SHALL have port: m_axis_tready  in  1  downstream accept.

Function
REQ-011 SHALL implement an N=1 CIC interpolator in this order: comb at the input rate, zero-stuff by R, integrator at the output rate.
REQ-012 SHALL have net gain 1, so every output phase equals the accepted input sample.
REQ-013 Comb SHALL compute d = x - x_prev in 14-bit signed arithmetic, then set x_prev <= x on each accepted input.
REQ-014 Integrator SHALL compute acc <= acc + d on phase 0 and acc <= acc + 0 on phases 1..R-1.
REQ-015 acc SHALL be 14-bit modular (wrap-around); m_axis_tdata = acc[12:0].
REQ-016 SHALL use two states.
  - IDLE: no sample held; m_axis_tvalid=0.
  - RUN: emitting phases 0..R-1; m_axis_tvalid=1.
REQ-017 SHALL hold a phase counter (9b) that advances only on an output transfer (m_axis_tvalid & m_axis_tready).
REQ-018 SHALL drive s_axis_tready = (state==IDLE) | (phase==R_q-1 & m_axis_tready); it is combinational from m_axis_tready.
REQ-019 An input accepted in cycle n SHALL present its phase-0 output in cycle n+1 (latency 1).
REQ-020 SHALL latch R_q from msetting at each input acceptance; a msetting change mid-burst takes effect at the next input.
REQ-021 On the last-phase transfer:
  - with simultaneous input acceptance: stay in RUN, set phase=0, produce no gap.
  - without input acceptance: go to IDLE, m_axis_tvalid=0 next cycle.
REQ-022 With m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and phase SHALL hold stable.
REQ-023 SHALL sustain continuous 1-sample/cycle throughput in both directions when R=1 and m_axis_tready=1.

Reset
REQ-024 On sync_reset=1, the block SHALL clear acc, x_prev, phase, R_q(=1), m_axis_tdata to 0 and m_axis_tvalid to 0, and set state to IDLE at the next edge.
REQ-025 During reset, s_axis_tready SHALL be 0; no input is accepted in a reset cycle.
REQ-026 Reset mid-burst SHALL abort the remaining phases; the first sample after reset SHALL output exactly its own value.

Configuration
REQ-027 Macro CIC_INTERP_TLAST_EN defined SHALL add port m_axis_tlast  out  1, asserted with m_axis_tvalid on phase R_q-1, and reset to 0.
REQ-028 Without CIC_INTERP_TLAST_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 R=4, inputs 100 then -50 back-to-back, tready=1 -> tdata 100,100,100,100,-50,-50,-50,-50 on consecutive cycles; no tvalid gap.
REQ-030 R=1, inputs 1..8 continuous, tready=1 -> outputs 1..8 one per cycle, each 1 cycle after its input; s_axis_tready stays 1.
REQ-031 R=3, tready low for 5 cycles after phase 1 -> tdata stable throughout the stall; exactly 3 transfers total; s_axis_tready=0 while stalled.
REQ-032 R=2, inputs 4095 then -4096 then 0 -> outputs 4095,4095,-4096,-4096,0,0 (wrap exercised).
REQ-033 R=8, sync_reset after 2 transfers -> tvalid=0 next cycle; next input 7 -> exactly eight outputs of 7.
REQ-034 msetting=0 -> 1 output per input; msetting=256 -> 256 outputs; with CIC_INTERP_TLAST_EN, tlast is set only on the 256th.

Source files
------------

// File: rtl/cic_interp_m256_n1_iw13.sv
// cic_interp_m256_n1_iw13
// First-order CIC interpolator with a run-time rate of 1..256.
// Signal path: comb at the input rate, zero-stuff by R, integrator at the
// output rate. Net gain is 1, so each input appears R times at the output.
// Optional build macro: CIC_INTERP_TLAST_EN adds m_axis_tlast, which marks
// the final output phase of each input sample.
module cic_interp_m256_n1_iw13 (
  input  logic               clk,
  input  logic               sync_reset,
  input  logic [8:0]         msetting,
  input  logic               s_axis_tvalid,
  input  logic signed [12:0] s_axis_tdata,
  output logic               s_axis_tready,
  output logic               m_axis_tvalid,
  output logic signed [12:0] m_axis_tdata,
`ifdef CIC_INTERP_TLAST_EN
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
`else
  input  logic               m_axis_tready
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [8:0]         phase;
  logic [8:0]         r_q;
  logic [8:0]         r_next;
  logic signed [12:0] x_prev;
  logic signed [13:0] acc;
  logic signed [13:0] diff;
  logic               last_phase;
  logic               out_xfer;
  logic               in_accept;

  // A rate setting of zero behaves as rate one.
  assign r_next     = (msetting == 9'd0) ? 9'd1 : msetting;
  assign last_phase = (phase == (r_q - 9'd1));
  assign out_xfer   = m_axis_tvalid & m_axis_tready;

  // A new sample is taken when idle, or when the last phase of the current
  // sample leaves in this same cycle, so bursts chain without a gap.
  assign s_axis_tready = ~sync_reset & ((state == IDLE) | (last_phase & m_axis_tready));
  assign in_accept     = s_axis_tvalid & s_axis_tready;

  // Comb stage in 14-bit signed arithmetic.
  assign diff = {s_axis_tdata[12], s_axis_tdata} - {x_prev[12], x_prev};

  // Integrator output; the zero-stuffed phases add nothing, so acc holds.
  assign m_axis_tdata = acc[12:0];

  // Comb history and integrator, both advancing only when a sample is taken.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      x_prev <= '0;
      acc    <= '0;
    end else if (in_accept) begin
      x_prev <= s_axis_tdata;
      acc    <= acc + diff;
    end
  end

  // Burst sequencer: tracks the output phase and the rate latched per sample.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state         <= IDLE;
      phase         <= '0;
      r_q           <= 9'd1;
      m_axis_tvalid <= 1'b0;
    end else if (in_accept) begin
      state         <= RUN;
      phase         <= '0;
      r_q           <= r_next;
      m_axis_tvalid <= 1'b1;
    end else if (out_xfer) begin
      if (last_phase) begin
        state         <= IDLE;
        phase         <= '0;
        m_axis_tvalid <= 1'b0;
      end else begin
        phase <= phase + 9'd1;
      end
    end
  end

`ifdef CIC_INTERP_TLAST_EN
  // Last-phase marker, registered alongside the phase it describes.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      m_axis_tlast <= 1'b0;
    end else if (in_accept) begin
      m_axis_tlast <= (r_next == 9'd1);
    end else if (out_xfer) begin
      if (last_phase) begin
        m_axis_tlast <= 1'b0;
      end else begin
        m_axis_tlast <= ((phase + 9'd1) == (r_q - 9'd1));
      end
    end
  end
`endif

endmodule
